// File: rtl/display_pkg.sv
// Shared types and constants for the hex display word queue.
// Provides WORD_W, the controller state enum and width helpers.
package display_pkg;

  localparam int WORD_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Dwell timer width: holds hold-1, never narrower than 1 bit.
  function automatic int tmr_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/display_word_queue_fifo.sv
// word_fifo: synchronous circular FIFO with flush.
// Ports: clk, reset_n, push, pop, din, dout, count, full, empty, flush.
module word_fifo
  import display_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WORD_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              dout,
  output logic [occ_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int CW = occ_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/display_word_queue.sv
// Word queue feeding the 4-digit hex display; each word dwells HOLD_CYCLES.
// Ports: clk, reset_n, in_valid/in_word/in_ready, flush, word, showing, count.
module display_word_queue
  import display_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic [WORD_W-1:0]       in_word,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WORD_W-1:0]       word,
  output logic                    showing,
  output logic [occ_w(DEPTH)-1:0] count
);

  localparam int TW = tmr_w(HOLD_CYCLES);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);

  state_e            state_q;
  logic [TW-1:0]     tmr_q;
  logic [WORD_W-1:0] word_q;
  logic              show_q;

  logic [WORD_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;

  // Pop decisions use registered occupancy only; a word arriving on
  // the expiry edge is picked up from IDLE one cycle later.
  assign pop = !flush && !empty &&
               ((state_q == IDLE) || (tmr_q == '0));

  word_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (in_word),
    .dout    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      word_q  <= '0;
      show_q  <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      show_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            word_q  <= head;
            tmr_q   <= HOLD_LD;
            state_q <= HOLD;
            show_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - TW'(1);
          end else if (pop) begin
            word_q <= head;
            tmr_q  <= HOLD_LD;
          end else begin
            state_q <= IDLE;
            show_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          show_q  <= 1'b0;
        end
      endcase
    end
  end

  assign word    = word_q;
  assign showing = show_q;

endmodule

// File: tb/tb_display_word_queue.sv
// Self-checking bench for display_word_queue (DEPTH=4, HOLD_CYCLES=4).
// Compares every cycle against a queue-based dwell model.
module tb_display_word_queue;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_word;
  logic        in_ready;
  logic        flush;
  logic [15:0] word;
  logic        showing;
  logic [2:0]  count;

  display_word_queue #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_word  (in_word),
    .in_ready (in_ready),
    .flush    (flush),
    .word     (word),
    .showing  (showing),
    .count    (count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: waiting words, the word on display and its age in cycles.
  logic [15:0] mq[$];
  logic [15:0] shown[$];
  logic [15:0] taken[$];
  logic [15:0] m_cur = '0;
  bit          m_busy = 0;
  int          m_age = 0;
  bit          last_acc;
  bit          saw_full;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cur  = '0;
    m_busy = 0;
    m_age  = 0;
  endtask

  task automatic tick();
    bit          fl, v;
    logic [15:0] d;
    int          occ;
    fl  = flush;
    v   = in_valid;
    d   = in_word;
    occ = mq.size();
    @(posedge clk);
    last_acc = 0;
    if (fl) begin
      mq.delete();
      m_busy = 0;
    end else begin
      if (occ > 0 && (!m_busy || m_age == HOLD)) begin
        m_cur  = mq.pop_front();
        m_busy = 1;
        m_age  = 1;
        shown.push_back(m_cur);
      end else if (m_busy && m_age == HOLD) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_age++;
      end
      if (v && occ < DEPTH) begin
        mq.push_back(d);
        taken.push_back(d);
        last_acc = 1;
      end
    end
    #1;
    if (!in_ready) saw_full = 1;
    chk("word", 32'(word), 32'(m_cur));
    chk("showing", 32'(showing), 32'(m_busy));
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    in_valid = 0;
    while ((m_busy || mq.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_drain_bound"}, 32'(n < 200), 32'd1);
    tick();
  endtask

  task automatic order(input string tag);
    chk({tag, "_len"}, 32'(shown.size()), 32'(taken.size()));
    for (int i = 0; i < shown.size() && i < taken.size(); i++)
      chk({tag, "_order"}, 32'(shown[i]), 32'(taken[i]));
    shown.delete();
    taken.delete();
  endtask

  task automatic push1(input logic [15:0] d);
    in_valid = 1;
    in_word  = d;
    tick();
    in_valid = 0;
  endtask

  logic [15:0] burst[6];
  logic [15:0] w5[10];

  initial begin
    reset_n  = 0;
    in_valid = 0;
    in_word  = '0;
    flush    = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", 32'(word), 32'h0);
    chk("rst_show", 32'(showing), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    reset_n = 1;
    repeat (3) tick();

    // Single word: latency 2, hold 4, then word retained.
    push1(16'h1234);
    chk("t2_cnt1", 32'(count), 32'd1);
    chk("t2_noshow", 32'(showing), 32'd0);
    tick();
    chk("t2_word", 32'(word), 32'h1234);
    chk("t2_show", 32'(showing), 32'd1);
    repeat (3) tick();
    chk("t2_still", 32'(showing), 32'd1);
    tick();
    chk("t2_off", 32'(showing), 32'd0);
    repeat (6) tick();
    chk("t2_keep", 32'(word), 32'h1234);
    shown.delete();
    taken.delete();

    // Asynchronous reset in the middle of a hold window.
    push1(16'h4321);
    repeat (2) tick();
    #2;
    reset_n = 0;
    #1;
    chk("ar_word", 32'(word), 32'h0);
    chk("ar_show", 32'(showing), 32'h0);
    chk("ar_count", 32'(count), 32'h0);
    chk("ar_ready", 32'(in_ready), 32'h1);
    model_reset();
    shown.delete();
    taken.delete();
    @(negedge clk);
    reset_n = 1;
    repeat (4) tick();

    // Burst into a full queue with in_valid held.
    burst = '{16'h1111, 16'hAAAA, 16'hBBBB,
              16'hCCCC, 16'hDDDD, 16'hEEEE};
    saw_full = 0;
    for (int i = 0, n = 0; i < 6 && n < 100; n++) begin
      in_valid = 1;
      in_word  = burst[i];
      tick();
      if (last_acc) i++;
    end
    chk("t3_full", 32'(saw_full), 32'd1);
    drain("t3");
    order("t3");

    // Flush during HOLD of AAAA with two queued; coincident push dropped.
    in_valid = 1;
    in_word = 16'hAAAA; tick();
    in_word = 16'hBBBB; tick();
    in_word = 16'hCCCC; tick();
    chk("t4_pre_cnt", 32'(count), 32'd2);
    flush   = 1;
    in_word = 16'h5555;
    tick();
    flush    = 0;
    in_valid = 0;
    chk("t4_cnt", 32'(count), 32'd0);
    chk("t4_show", 32'(showing), 32'd0);
    chk("t4_word", 32'(word), 32'hAAAA);
    repeat (8) tick();
    chk("t4_keep", 32'(word), 32'hAAAA);
    shown.delete();
    taken.delete();

    // Random bursts and gaps: queue fills and drains, pointers wrap.
    for (int i = 0; i < 10; i++)
      w5[i] = {4'(i), 12'($urandom)};
    begin
      int idx = 0;
      int guard = 0;
      bit burst_mode = 1;
      while (idx < 10 && guard < 2000) begin
        int len;
        if (burst_mode) begin
          len = $urandom_range(8, 3);
          for (int k = 0; k < len && idx < 10; k++) begin
            in_valid = 1;
            in_word  = w5[idx];
            tick();
            guard++;
            chk("t5_cap", 32'(count <= 3'(DEPTH)), 32'd1);
            if (last_acc) idx++;
          end
        end else begin
          len = $urandom_range(14, 6);
          in_valid = 0;
          for (int k = 0; k < len; k++) begin
            tick();
            guard++;
          end
        end
        burst_mode = !burst_mode;
      end
      chk("t5_all_in", 32'(idx), 32'd10);
    end
    drain("t5");
    order("t5");

    // Push on the expiry edge with an empty queue: one IDLE cycle.
    push1(16'h7E57);
    tick();
    chk("t6_show", 32'(word), 32'h7E57);
    repeat (3) tick();
    in_valid = 1;
    in_word  = 16'h0BEE;
    tick();
    in_valid = 0;
    chk("t6_gap_show", 32'(showing), 32'd0);
    chk("t6_gap_cnt", 32'(count), 32'd1);
    tick();
    chk("t6_word", 32'(word), 32'h0BEE);
    chk("t6_on", 32'(showing), 32'd1);
    repeat (3) tick();
    chk("t6_hold", 32'(showing), 32'd1);
    tick();
    chk("t6_end", 32'(showing), 32'd0);
    drain("t6");
    order("t6");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/display_word_queue.md
Name: display_word_queue

Overview:
- Upstream feeder for the 4-digit hex display path: buffers 16-bit words pushed by the CPU or debug logic.
- Presents one word at a time on `word`, which drives the 4-digit word display stage.
- Holds each word for at least HOLD_CYCLES clocks, so that fast bursts of writes stay readable on the seven-segment digits.
- Contains a small FIFO, a dwell timer and a two-state controller.

Parameters:
- WORD_W, 16: width of each displayed word. Fixed at 16 for the 4-digit display. Exposed only for the package constant.
- DEPTH, 4: FIFO entries. Must be a power of two, at least 2.
- HOLD_CYCLES, 50000000: minimum display time per word, in clocks (1 s at 50 MHz). Must be at least 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer offers in_word this cycle
- in_word  in  WORD_W  word to queue
- in_ready  out  1  queue can accept; a push occurs when in_valid && in_ready
- flush  in  1  synchronous clear of the queue
- word  out  WORD_W  word currently shown; feeds the display stage
- showing  out  1  high while a word is within its hold window
- count  out  clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset values (async, while reset_n=0):
  - word=16'h0000, showing=0, count=0, in_ready=1.
  - Controller in IDLE, timer=0, FIFO pointers=0.
  - Reset takes effect immediately, without a clock edge, including mid-hold.
- in_ready = (count != DEPTH). It is registered-state only and does not depend on a same-cycle pop. A push into a full FIFO cannot occur; in_valid with in_ready low is ignored, and the producer must hold the data.
- FIFO: circular buffer with read/write pointers that wrap modulo DEPTH.
  - Push and pop in the same cycle leaves count unchanged.
- Controller states:
  - IDLE: showing=0; word retains its last value.
    - If count!=0: pop head into word, load timer=HOLD_CYCLES-1, go to HOLD.
  - HOLD: showing=1.
    - If timer!=0: decrement the timer.
    - If timer==0 and count!=0: pop the next word into word, reload timer, stay in HOLD.
    - If timer==0 and count==0: go to IDLE. word is retained.
- Timing consequences:
  - Back-to-back queued words are each shown for exactly HOLD_CYCLES cycles.
  - Latency: a word pushed at edge N into an empty FIFO while IDLE appears on word after edge N+1, i.e. 2 cycles from in_valid assertion. showing rises in the same cycle.
  - A word pushed while in HOLD with timer==0 in that same cycle is not popped until the next cycle, because pop decisions use registered count.
- flush=1 at an edge:
  - count←0, pointers←0, state←IDLE, showing←0, timer←0. word is retained.
  - A push coincident with flush is dropped.
  - flush has priority over pop.
- Width rule: the timer is clog2(HOLD_CYCLES) bits, minimum 1, and loads from the truncated constant HOLD_CYCLES-1.

Decomposition:
- Shared package display_pkg:
  - WORD_W=16 constant.
  - State enum {IDLE, HOLD}.
  - Function for the occupancy width.
- One natural sub-module: word_fifo, a synchronous FIFO with the same clk/reset_n and ports push, pop, din, dout, count, full, empty, flush. It is reused elsewhere for UART/debug buffering.
- Controller and timer stay in display_word_queue.

Test Plan (HOLD_CYCLES=4, DEPTH=4):
1. Assert reset_n=0 mid-run with no clock -> word=0000, showing=0, count=0, in_ready=1 immediately. After release, outputs are stable with no spurious pop.
2. In IDLE, push 0x1234 at edge 0 -> word=0x1234 and showing=1 after edge 1, held 4 cycles. Then showing=0 and word stays 0x1234 indefinitely.
3. Push 0x1111, then burst 0xAAAA,0xBBBB,0xCCCC,0xDDDD,0xEEEE with in_valid held high -> in_ready drops at count=4. 0xEEEE is accepted when a slot frees. Display order is 1111,AAAA,BBBB,CCCC,DDDD,EEEE, each exactly 4 cycles, with no gap and no loss.
4. During HOLD of 0xAAAA with 2 queued, assert flush together with in_valid=1 (0x5555) -> next cycle count=0, showing=0, word=0xAAAA. 0x5555 is never displayed.
5. Push 10 distinct words spaced so the FIFO alternately fills and drains -> pointers wrap and output order exactly matches input order. count never exceeds 4 and never underflows.
6. Push exactly when the timer hits 0 with an empty FIFO -> controller goes to IDLE for 1 cycle (showing=0), then shows the new word with a full 4-cycle hold.
